// File: rtl/display_pkg.sv
// Shared constants and types for the six-digit multiplexed display scanner.
package display_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_W      = 16;

  typedef logic [6:0] seg_t;

  localparam seg_t              SEG_OFF  = 7'h7F;
  localparam seg_t              SEG_ZERO = 7'b0000001;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_tick_counter.sv
// Loadable down-counter that times how long each scan phase lasts.
// tc_c is high while the count sits at zero, so a phase loaded with N-1 lasts N cycles.
module scan_tick_counter
  import display_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         sys_clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] count;

  // Reload has priority, clear parks the counter, otherwise count down to zero.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clear) begin
      count <= '0;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/display_scan_driver.sv
// Six-digit multiplexed 7-segment scan driver with per-frame digit snapshot.
// Optional macro SCAN_BLANK_EN inserts BLANK_CYCLES all-off cycles after each
// digit to suppress ghosting; without it digits switch back-to-back.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       display_en,
  input  logic [NUM_DIGITS-1:0][6:0] digit_in,
  output logic [6:0]                 seg_out,
  output logic [NUM_DIGITS-1:0]      an_out,
  output logic                       frame_done
);

  localparam logic [1:0]       IDLE       = 2'(ST_IDLE);
  localparam logic [1:0]       DRIVE      = 2'(ST_DRIVE);
  localparam logic [1:0]       BLANK      = 2'(ST_BLANK);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LOAD = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  logic [1:0]                state, state_d;
  logic [IDX_W-1:0]          idx, idx_d;
  seg_t [NUM_DIGITS-1:0]     snap, snap_d;
  seg_t                      seg_d;
  logic [NUM_DIGITS-1:0]     an_d;
  logic                      fd_d;
  logic                      cnt_load_c;
  logic                      cnt_clear_c;
  logic [CNT_W-1:0]          cnt_val_c;
  logic                      tick_c;
  logic                      advance_c;

  scan_tick_counter #(.W(CNT_W)) u_tick (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (cnt_clear_c),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .tc_c     (tick_c)
  );

  // Next-state, snapshot and registered-output values for the scan FSM.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    snap_d      = snap;
    fd_d        = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_clear_c = 1'b0;
    cnt_val_c   = DRIVE_LOAD;
    advance_c   = 1'b0;
    seg_d       = SEG_OFF;
    an_d        = AN_OFF;

    case (state)
      IDLE: begin
        idx_d = '0;
        if (display_en) begin
          snap_d     = digit_in;
          state_d    = DRIVE;
          cnt_load_c = 1'b1;
        end else begin
          cnt_clear_c = 1'b1;
        end
      end
      DRIVE: begin
        if (!display_en) begin
          state_d     = IDLE;
          idx_d       = '0;
          cnt_clear_c = 1'b1;
        end else if (tick_c) begin
`ifdef SCAN_BLANK_EN
          state_d    = BLANK;
          cnt_load_c = 1'b1;
`else
          advance_c  = 1'b1;
`endif
        end
      end
      BLANK: begin
        if (!display_en) begin
          state_d     = IDLE;
          idx_d       = '0;
          cnt_clear_c = 1'b1;
        end else if (tick_c) begin
          advance_c = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        idx_d       = '0;
        cnt_clear_c = 1'b1;
      end
    endcase

    // Step to the next digit; wrapping past the last one closes the frame.
    if (advance_c) begin
      state_d    = DRIVE;
      cnt_load_c = 1'b1;
      if (idx == LAST_IDX) begin
        idx_d  = '0;
        fd_d   = 1'b1;
        snap_d = digit_in;
      end else begin
        idx_d = idx + IDX_W'(1);
      end
    end

    if (state_d == BLANK) begin
      cnt_val_c = BLANK_LOAD;
    end

    if (state_d == DRIVE) begin
      seg_d = snap_d[idx_d];
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  // State, snapshot and output registers; reset blanks everything immediately.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      snap       <= {NUM_DIGITS{SEG_OFF}};
      seg_out    <= SEG_OFF;
      an_out     <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      snap       <= snap_d;
      seg_out    <= seg_d;
      an_out     <= an_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver (SCAN_DIV=4, BLANK_CYCLES=2).
// Expected values come from a frame-position model; SCAN_BLANK_EN selects
// the blanked timing in both the DUT and the model.
module tb_display_scan_driver;
  import display_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
`ifdef SCAN_BLANK_EN
  localparam int PER = SCAN_DIV + BLANK_CYCLES;
`else
  localparam int PER = SCAN_DIV;
`endif
  localparam int FRAME = 6 * PER;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic            display_en;
  logic [5:0][6:0] digit_in;
  logic [6:0]      seg_out;
  logic [5:0]      an_out;
  logic            frame_done;

  exp_t            sb_q[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  int              fd_seen  = 0;
  bit              m_active = 1'b0;
  int              m_t      = 0;
  logic [5:0][6:0] m_snap;
  logic [5:0]      an_tab [6];

  display_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .display_en (display_en),
    .digit_in   (digit_in),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Never more than one anode low, checked on every falling edge.
  always @(negedge sys_clk) begin
    n_checks++;
    assert ($countones(~an_out) <= 1) n_pass++;
    else $error("FAIL onehot: observed an_out %0h expected at most one zero bit", an_out);
  end

  function automatic int cur_digit();
    return (m_t % FRAME) / PER;
  endfunction

  // Predict outputs after the coming edge from the inputs now applied.
  task automatic predict();
    exp_t e;
    int   pos;
    e.an  = 6'h3F;
    e.seg = SEG_OFF;
    e.fd  = 1'b0;
    if (rst || !display_en) begin
      m_active = 1'b0;
    end else begin
      if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
        m_snap   = digit_in;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_snap = digit_in;
          e.fd   = 1'b1;
        end
      end
      pos = m_t % FRAME;
      if (pos % PER < SCAN_DIV) begin
        e.an  = an_tab[pos / PER];
        e.seg = m_snap[pos / PER];
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    predict();
    @(posedge sys_clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, ".an"},  32'(an_out),     32'(e.an));
    chk({tag, ".seg"}, 32'(seg_out),    32'(e.seg));
    chk({tag, ".fd"},  32'(frame_done), 32'(e.fd));
    if (frame_done === 1'b1) fd_seen++;
  endtask

  initial begin
    an_tab = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    rst        = 1'b1;
    display_en = 1'b0;
    for (int i = 0; i < 6; i++) digit_in[i] = SEG_ZERO + 7'(i);

    // Reset applies before any clock edge.
    #1;
    chk("reset.seg", 32'(seg_out),    32'h7F);
    chk("reset.an",  32'(an_out),     32'h3F);
    chk("reset.fd",  32'(frame_done), 32'h0);
    repeat (2) step("rst_hold");
    rst = 1'b0;
    repeat (2) step("idle");

    // Two full frames plus the wrap edge.
    display_en = 1'b1;
    fd_seen    = 0;
    repeat (2 * FRAME + 1) step("scan");
    chk("frame_count", 32'(fd_seen), 32'd2);

    // Change digit 3 while digit 1 is shown.
    for (int k = 0; k < FRAME; k++) begin
      if (cur_digit() == 1) break;
      step("snap_wait");
    end
    digit_in[3] = 7'h4F;
    repeat (2 * FRAME) step("snap");

    // Abort during digit 4, then restart with fresh data.
    for (int k = 0; k < FRAME; k++) begin
      if (cur_digit() == 4) break;
      step("abort_wait");
    end
    display_en = 1'b0;
    fd_seen    = 0;
    step("abort");
    repeat (3) step("dark");
    chk("abort_no_fd", 32'(fd_seen), 32'd0);
    digit_in[0] = 7'h12;
    display_en  = 1'b1;
    repeat (FRAME + 2) step("restart");

    // Asynchronous reset while a digit is lit.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.seg", 32'(seg_out),    32'h7F);
    chk("async_rst.an",  32'(an_out),     32'h3F);
    chk("async_rst.fd",  32'(frame_done), 32'h0);
    step("rst_mid");
    rst = 1'b0;
    repeat (FRAME + 2) step("resume");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 The block SHALL have a parameter SCAN_DIV, default 1000: number of sys_clk cycles each digit is driven (legal range 2..65535).
REQ-002 The block SHALL have a parameter BLANK_CYCLES, default 16: number of all-off sys_clk cycles after each digit (legal range 1..255, used only with SCAN_BLANK_EN).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port display_en, input, 1 bit: high = scan active, low = display dark.
REQ-006 The block SHALL have port digit_in, input, [5:0][6:0]: six active-low 7-segment codes from the timer, index 0 = seconds units, index 5 = hours tens.
REQ-007 The block SHALL have port seg_out, output, 7 bits: active-low segment drive, registered.
REQ-008 The block SHALL have port an_out, output, 6 bits: active-low one-hot digit anode select, registered.
REQ-009 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse at the end of each complete six-digit scan.

Function
REQ-010 The FSM SHALL have states IDLE, DRIVE and BLANK; BLANK is reachable only with SCAN_BLANK_EN.
REQ-011 In IDLE: seg_out=7'h7F, an_out=6'h3F, digit index=0, dwell counter=0.
REQ-012 IDLE with display_en=1 sampled SHALL capture digit_in into a six-entry snapshot register and enter DRIVE at index 0 on the same edge.
REQ-013 In DRIVE: an_out=~(6'b1<<idx), seg_out=snapshot[idx], for exactly SCAN_DIV cycles.
REQ-014 At DRIVE terminal count: with SCAN_BLANK_EN -> BLANK; without -> DRIVE at idx+1 directly.
REQ-015 In BLANK: seg_out=7'h7F, an_out=6'h3F for exactly BLANK_CYCLES cycles, then DRIVE at idx+1.
REQ-016 After idx 5 completes (DRIVE or BLANK as configured): idx wraps to 0, frame_done=1 for one cycle, snapshot re-captured from digit_in on that edge.
REQ-017 digit_in changes mid-frame SHALL NOT affect seg_out until the next frame capture (no tearing).
REQ-018 display_en=0 sampled in any state SHALL force IDLE on the next edge; no frame_done is issued for the aborted frame.
REQ-019 Exactly zero or one bit of an_out SHALL be low in every cycle.
REQ-020 Frame period SHALL be 6*SCAN_DIV cycles, or 6*(SCAN_DIV+BLANK_CYCLES) with SCAN_BLANK_EN.

Reset
REQ-021 rst=1 SHALL asynchronously force IDLE, seg_out=7'h7F, an_out=6'h3F, frame_done=0, idx=0, counter=0, snapshot entries=7'h7F.
REQ-022 Reset asserted mid-frame SHALL take effect immediately without waiting for a clock edge; scanning resumes per REQ-012 after release.

Configuration
REQ-023 Macro SCAN_BLANK_EN defined SHALL compile in the BLANK state and the BLANK_CYCLES inter-digit anti-ghosting gap.
REQ-024 Without SCAN_BLANK_EN, digits SHALL switch back-to-back with no off cycles, and BLANK_CYCLES SHALL be ignored.

Structure
REQ-025 Package display_pkg SHALL hold NUM_DIGITS=6, SEG_OFF=7'h7F, SEG_ZERO=7'b0000001, typedef seg_t (logic [6:0]) and the scan state enum.
REQ-026 Dwell timing SHALL be a sub-module scan_tick_counter (load value, count down, terminal-count pulse, clear), instanced once and reloaded with SCAN_DIV or BLANK_CYCLES per state.

Verification
REQ-027 Reset: rst=1 mid-DRIVE -> seg_out=7'h7F, an_out=6'h3F, frame_done=0 with no clock edge required.
REQ-028 Scan order: SCAN_DIV=4, no macro, display_en=1, digit_in[i]=SEG_ZERO+i -> an_out steps 3E,3D,3B,37,2F,1F every 4 cycles, seg_out matches, frame_done pulses once per 24 cycles.
REQ-029 Blanking: SCAN_BLANK_EN, SCAN_DIV=4, BLANK_CYCLES=2 -> each digit 4 cycles lit then 2 cycles an_out=6'h3F; frame period 36 cycles.
REQ-030 Snapshot: change digit_in[3] while idx=1 -> digit 3 shows old code this frame, new code next frame.
REQ-031 Abort: drop display_en during idx 4 -> next cycle IDLE, outputs off, no frame_done; re-assert -> restart at idx 0 with fresh capture.
REQ-032 One-hot check: assertion over all tests that an_out never has more than one zero bit.
